// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and constants for the ROM download streamer
package rom_dl_pkg;

   localparam int ROMAD_W       = 16;
   localparam int ROMDT_W       = 8;
   localparam int LEN_W         = ROMAD_W + 1;
   localparam int DEF_SETUP_CYC = 2;
   localparam int DEF_HIGH_CYC  = 2;
   localparam int DEF_HOLD_CYC  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SETUP,
      ST_HIGH,
      ST_HOLD,
      ST_FIN
   } dl_state_t;

   // Phase timer must hold the largest phase length minus one.
   function automatic int timer_width(input int s, input int h, input int o);
      int m;
      int w;
      m = (s > h) ? s : h;
      m = (m > o) ? m : o;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dl_phase_timer.sv
// rtl/dl_phase_timer.sv - loadable down-counter timing the SETUP/HIGH/HOLD phases
module dl_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/rom_dl_streamer.sv
// rtl/rom_dl_streamer.sv - writes a host byte stream onto the DLROM download bus
module rom_dl_streamer
   import rom_dl_pkg::*;
#(
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int HIGH_CYC  = DEF_HIGH_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic               MCLK,
   input  logic               RESET_N,
   input  logic               START,
   input  logic [ROMAD_W-1:0] BASE,
   input  logic [LEN_W-1:0]   LENGTH,
   input  logic               ABORT,
   input  logic               SRC_VALID,
   input  logic [ROMDT_W-1:0] SRC_DATA,
   output logic               SRC_READY,
   output logic               ROMCL,
   output logic [ROMAD_W-1:0] ROMAD,
   output logic [ROMDT_W-1:0] ROMDT,
   output logic               ROMEN,
   output logic               BUSY,
   output logic               DONE,
   output logic [ROMDT_W-1:0] SUM
);

   localparam int            TW       = timer_width(SETUP_CYC, HIGH_CYC, HOLD_CYC);
   localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] HIGH_LD  = TW'(HIGH_CYC - 1);
   localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

   dl_state_t          state;
   logic [ROMAD_W-1:0] addr;
   logic [LEN_W-1:0]   count;
   logic               abort_pend;
   logic               tmr_load;
   logic [TW-1:0]      tmr_value;
   logic               tmr_expired;

   dl_phase_timer #(.W(TW)) u_timer (
      .clk     (MCLK),
      .rst_n   (RESET_N),
      .load    (tmr_load),
      .value   (tmr_value),
      .expired (tmr_expired)
   );

   // Each phase loads the length of the phase that follows it.
   always_comb begin
      tmr_load  = 1'b0;
      tmr_value = '0;
      case (state)
         ST_FETCH: begin tmr_load = 1'b1;        tmr_value = SETUP_LD; end
         ST_SETUP: begin tmr_load = tmr_expired; tmr_value = HIGH_LD;  end
         ST_HIGH:  begin tmr_load = tmr_expired; tmr_value = HOLD_LD;  end
         default:  ;
      endcase
   end

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= ST_IDLE;
         addr       <= '0;
         count      <= '0;
         abort_pend <= 1'b0;
         SRC_READY  <= 1'b0;
         ROMCL      <= 1'b0;
         ROMAD      <= '0;
         ROMDT      <= '0;
         ROMEN      <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         SUM        <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  addr       <= BASE;
                  count      <= LENGTH;
                  SUM        <= '0;
                  BUSY       <= 1'b1;
                  abort_pend <= 1'b0;
                  if (LENGTH == '0) begin
                     state <= ST_FIN;
                  end else begin
                     state     <= ST_FETCH;
                     SRC_READY <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (ABORT) begin
                  state     <= ST_IDLE;
                  SRC_READY <= 1'b0;
                  BUSY      <= 1'b0;
               end else if (SRC_VALID && SRC_READY) begin
                  state     <= ST_SETUP;
                  SRC_READY <= 1'b0;
                  ROMDT     <= SRC_DATA;
                  ROMAD     <= addr;
                  ROMEN     <= 1'b1;
                  SUM       <= SUM + SRC_DATA;
               end
            end
            ST_SETUP: begin
               if (ABORT) begin
                  state <= ST_IDLE;
                  ROMEN <= 1'b0;
                  BUSY  <= 1'b0;
               end else if (tmr_expired) begin
                  state <= ST_HIGH;
                  ROMCL <= 1'b1;
               end
            end
            ST_HIGH: begin
               if (ABORT) abort_pend <= 1'b1;
               if (tmr_expired) begin
                  state <= ST_HOLD;
                  ROMCL <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (ABORT) abort_pend <= 1'b1;
               if (tmr_expired) begin
                  ROMEN <= 1'b0;
                  addr  <= addr + 1'b1;
                  count <= count - 1'b1;
                  // Once the write has been framed, a late abort simply ends the transfer.
                  if (abort_pend || ABORT) begin
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                  end else if (count == LEN_W'(1)) begin
                     state <= ST_FIN;
                  end else begin
                     state     <= ST_FETCH;
                     SRC_READY <= 1'b1;
                  end
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_dl_streamer.sv
// tb/tb_rom_dl_streamer.sv - self-checking bench for rom_dl_streamer
module tb_rom_dl_streamer;

   logic        MCLK, RESET_N, START, ABORT, SRC_VALID, SRC_READY;
   logic        ROMCL, ROMEN, BUSY, DONE;
   logic [15:0] BASE, ROMAD;
   logic [16:0] LENGTH;
   logic [7:0]  SRC_DATA, ROMDT, SUM;

   rom_dl_streamer dut (
      .MCLK      (MCLK),
      .RESET_N   (RESET_N),
      .START     (START),
      .BASE      (BASE),
      .LENGTH    (LENGTH),
      .ABORT     (ABORT),
      .SRC_VALID (SRC_VALID),
      .SRC_DATA  (SRC_DATA),
      .SRC_READY (SRC_READY),
      .ROMCL     (ROMCL),
      .ROMAD     (ROMAD),
      .ROMDT     (ROMDT),
      .ROMEN     (ROMEN),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .SUM       (SUM)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   typedef struct {
      logic [15:0] base;
      logic [16:0] len;
      logic [7:0]  d0;
      logic [7:0]  step;
      logic [7:0]  exp_sum;
      int          exp_done;
   } vec_t;

   localparam int TIMEOUT = 3000;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] cfg_base;
   logic [16:0] cfg_len;
   int          cfg_gap_pct, cfg_stall_at, cfg_stall_len, cfg_abort_rel;
   bit          cfg_spurious;
   logic [7:0]  bytes [0:63];
   int          res_writes, res_done_n, res_done_rel;
   logic [7:0]  res_sum;
   vec_t        vecs [5];

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic setup(input logic [15:0] b, input logic [16:0] l, input logic [7:0] d0,
                        input logic [7:0] st, input bit rnd);
      cfg_base      = b;
      cfg_len       = l;
      cfg_gap_pct   = 0;
      cfg_stall_at  = -1;
      cfg_stall_len = 0;
      cfg_abort_rel = -1;
      cfg_spurious  = 1'b0;
      for (int k = 0; k < 64; k++)
         bytes[k] = rnd ? 8'($urandom) : 8'(d0 + 8'(k) * st);
   endtask

   // Runs one transfer; the model expects write n at BASE+n carrying the n-th accepted byte.
   task automatic xfer(input int rst_rel);
      int          tail, widx, sidx, stall_left;
      bit          stalling, v, finished;
      logic        pcl;
      logic [15:0] pad;
      logic [7:0]  pdt, msum;
      widx = 0; sidx = 0; stall_left = cfg_stall_len; stalling = 1'b0; finished = 1'b0;
      msum = 8'h00; pcl = 1'b0; pad = '0; pdt = '0;
      res_done_n = 0; res_done_rel = -1; tail = -1;
      @(negedge MCLK);
      BASE = cfg_base; LENGTH = cfg_len; START = 1'b1;
      for (int rel = 1; rel <= TIMEOUT; rel++) begin
         @(negedge MCLK);
         if (ROMCL && !pcl) begin
            chk("wr_addr", 40'(ROMAD), 40'(16'(cfg_base + 16'(widx))));
            chk("wr_data", 40'(ROMDT), 40'(bytes[widx & 63]));
            chk("wr_en", 40'(ROMEN), 40'(1));
            if (cfg_gap_pct == 0 && cfg_stall_len == 0)
               chk("wr_cycle", 40'(rel), 40'(4 + 7 * widx));
            widx++;
         end else if (ROMCL) begin
            chk("bus_stable", 40'({ROMAD, ROMDT, ROMEN}), 40'({pad, pdt, 1'b1}));
         end
         pcl = ROMCL; pad = ROMAD; pdt = ROMDT;
         if (DONE) begin
            res_done_n++;
            res_done_rel = rel;
         end
         if (rel == 1) chk("busy_after_start", 40'(BUSY), 40'(1));
         if (rel == rst_rel) begin
            RESET_N = 1'b0;
            #1;
            chk("async_reset", 40'({ROMCL, ROMEN, BUSY}), 40'(0));
            START = 1'b0; ABORT = 1'b0; SRC_VALID = 1'b0;
            res_writes = widx;
            res_sum = msum;
            return;
         end
         ABORT = (rel == cfg_abort_rel);
         START = cfg_spurious && (rel == 5);
         if (START) begin
            BASE   = 16'($urandom);
            LENGTH = 17'($urandom_range(5, 1));
         end
         v = 1'b0;
         if (sidx < int'(cfg_len)) begin
            if (!stalling && stall_left > 0 && sidx == cfg_stall_at && SRC_READY) stalling = 1'b1;
            if (stalling && stall_left > 0) begin
               chk("stall_ready", 40'(SRC_READY), 40'(1));
               chk("stall_quiet", 40'({ROMCL, ROMEN}), 40'(0));
               stall_left--;
            end else begin
               v = (int'($urandom_range(99, 0)) >= cfg_gap_pct);
            end
         end
         SRC_VALID = v;
         SRC_DATA  = v ? bytes[sidx & 63] : 8'($urandom);
         if (v && SRC_READY) begin
            msum = msum + bytes[sidx & 63];
            sidx++;
         end
         if (tail < 0 && rel >= 2 && !BUSY) tail = rel + 8;
         if (rel == tail) begin
            finished = 1'b1;
            break;
         end
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL timeout actual=busy required=idle");
      end
      ABORT = 1'b0; SRC_VALID = 1'b0; START = 1'b0;
      res_writes = widx;
      res_sum = msum;
   endtask

   initial begin
      vecs[0] = '{base: 16'hD800, len: 17'd4, d0: 8'h01, step: 8'h01, exp_sum: 8'h0A, exp_done: 30};
      vecs[1] = '{base: 16'h1234, len: 17'd0, d0: 8'h55, step: 8'h01, exp_sum: 8'h00, exp_done: 2};
      vecs[2] = '{base: 16'hFFFE, len: 17'd3, d0: 8'h10, step: 8'h10, exp_sum: 8'h60, exp_done: 23};
      vecs[3] = '{base: 16'h0100, len: 17'd2, d0: 8'hF0, step: 8'h20, exp_sum: 8'h00, exp_done: 16};
      vecs[4] = '{base: 16'h0000, len: 17'd1, d0: 8'hAA, step: 8'h00, exp_sum: 8'hAA, exp_done: 9};

      RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0; SRC_VALID = 1'b0;
      BASE = '0; LENGTH = '0; SRC_DATA = '0;
      repeat (3) @(negedge MCLK);
      chk("reset_ctl", 40'({SRC_READY, ROMCL, ROMEN, BUSY, DONE}), 40'(0));
      chk("reset_bus", 40'({ROMAD, ROMDT, SUM}), 40'(0));
      RESET_N = 1'b1;

      foreach (vecs[i]) begin
         setup(vecs[i].base, vecs[i].len, vecs[i].d0, vecs[i].step, 1'b0);
         xfer(-1);
         chk("vec_writes", 40'(res_writes), 40'(vecs[i].len));
         chk("vec_done_n", 40'(res_done_n), 40'(1));
         chk("vec_done_cycle", 40'(res_done_rel), 40'(vecs[i].exp_done));
         chk("vec_sum", 40'(SUM), 40'(vecs[i].exp_sum));
      end

      setup(16'h4000, 17'd4, 8'h11, 8'h11, 1'b0);
      cfg_stall_at = 2; cfg_stall_len = 20;
      xfer(-1);
      chk("stall_writes", 40'(res_writes), 40'(4));
      chk("stall_done_n", 40'(res_done_n), 40'(1));
      chk("stall_sum", 40'(SUM), 40'(8'hAA));

      setup(16'h2000, 17'd4, 8'h05, 8'h01, 1'b0);
      cfg_abort_rel = 11;
      xfer(-1);
      chk("abort_high_writes", 40'(res_writes), 40'(2));
      chk("abort_high_done", 40'(res_done_n), 40'(0));
      chk("abort_high_sum", 40'(SUM), 40'(8'h0B));
      chk("abort_high_bus", 40'({ROMEN, ROMCL, BUSY}), 40'(0));

      setup(16'h2100, 17'd4, 8'h07, 8'h01, 1'b0);
      cfg_abort_rel = 9;
      xfer(-1);
      chk("abort_setup_writes", 40'(res_writes), 40'(1));
      chk("abort_setup_done", 40'(res_done_n), 40'(0));
      chk("abort_setup_en", 40'({ROMEN, BUSY}), 40'(0));

      setup(16'h3000, 17'd3, 8'h21, 8'h01, 1'b0);
      xfer(5);
      repeat (2) @(negedge MCLK);
      chk("in_reset", 40'({SRC_READY, ROMCL, ROMEN, BUSY, DONE, SUM}), 40'(0));
      RESET_N = 1'b1;
      setup(16'h7000, 17'd2, 8'h40, 8'h01, 1'b0);
      xfer(-1);
      chk("restart_writes", 40'(res_writes), 40'(2));
      chk("restart_done_cycle", 40'(res_done_rel), 40'(16));
      chk("restart_sum", 40'(SUM), 40'(8'h81));

      for (int it = 0; it < 8; it++) begin
         setup(16'($urandom), 17'($urandom_range(10, 1)), 8'h00, 8'h00, 1'b1);
         cfg_gap_pct  = 35;
         cfg_spurious = 1'b1;
         xfer(-1);
         chk("rnd_writes", 40'(res_writes), 40'(cfg_len));
         chk("rnd_done_n", 40'(res_done_n), 40'(1));
         chk("rnd_sum", 40'(SUM), 40'(res_sum));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
